// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width default and
// occupancy encoding for the selector pipe buffer.
package cpu_pkg;

   localparam int CPU_WIDTH = 32;

   typedef enum logic [1:0] {
      MSP_EMPTY = 2'd0,
      MSP_ONE   = 2'd1,
      MSP_FULL  = 2'd2
   } msp_state_e;

endpackage

// File: rtl/mux_sel_word.sv
// Combinational N:1 word pick from a flattened bus.
// Out-of-range selects yield zero and raise err.
module mux_sel_word
   import cpu_pkg::*;
#(
   parameter int WIDTH = CPU_WIDTH,
   parameter int N     = 3,
   parameter int SELW  = $clog2(N)
) (
   input  logic [N*WIDTH-1:0] data,
   input  logic [SELW-1:0]    sel,
   output logic [WIDTH-1:0]   word,
   output logic               err
);

   // Decode select; no match leaves the word at zero and flags it
   always_comb begin
      word = '0;
      err  = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (sel == SELW'(i)) begin
            word = data[i*WIDTH +: WIDTH];
            err  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered N-way word selector with valid/ready
// handshake, 2-entry skid buffer and flush.
module mux_sel_pipe
   import cpu_pkg::*;
#(
   parameter  int WIDTH = CPU_WIDTH,
   parameter  int N     = 3,
   localparam int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [SELW-1:0]    in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic               flush,
   output logic               sel_err
);

   msp_state_e       state_q;
   msp_state_e       state_n;
   logic             in_ready_q;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] skid_q;
   logic             sel_err_q;
   logic [WIDTH-1:0] pick;
   logic             pick_err;
   logic             accept;
   logic             drain;
   logic             head_ld;
   logic             skid_ld;
   logic             skid_mv;

   mux_sel_word #(
      .WIDTH (WIDTH),
      .N     (N),
      .SELW  (SELW)
   ) u_pick (
      .data  (in_data),
      .sel   (in_sel),
      .word  (pick),
      .err   (pick_err)
   );

   assign out_valid = (state_q != MSP_EMPTY);
   assign in_ready  = in_ready_q;
   assign out_data  = head_q;
   assign sel_err   = sel_err_q;
   assign accept    = in_valid & in_ready_q;
   assign drain     = out_valid & out_ready;

   // Occupancy transitions and buffer load enables
   always_comb begin
      state_n = state_q;
      head_ld = 1'b0;
      skid_ld = 1'b0;
      skid_mv = 1'b0;
      if (flush) begin
         state_n = MSP_EMPTY;
      end else begin
         unique case (state_q)
            MSP_EMPTY: begin
               if (accept) begin
                  head_ld = 1'b1;
                  state_n = MSP_ONE;
               end
            end
            MSP_ONE: begin
               if (accept && drain) begin
                  head_ld = 1'b1;
               end else if (accept) begin
                  skid_ld = 1'b1;
                  state_n = MSP_FULL;
               end else if (drain) begin
                  state_n = MSP_EMPTY;
               end
            end
            MSP_FULL: begin
               if (drain) begin
                  skid_mv = 1'b1;
                  state_n = MSP_ONE;
               end
            end
            default: state_n = MSP_EMPTY;
         endcase
      end
   end

   // State register; in_ready registered from next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= MSP_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_n;
         in_ready_q <= (state_n != MSP_FULL);
      end
   end

   // Head and skid word registers; flush leaves contents
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         skid_q <= '0;
      end else begin
         if (head_ld)
            head_q <= pick;
         else if (skid_mv)
            head_q <= skid_q;
         if (skid_ld)
            skid_q <= pick;
      end
   end

   // Sticky out-of-range flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst)
         sel_err_q <= 1'b0;
      else if (accept && pick_err)
         sel_err_q <= 1'b1;
   end

endmodule
